// File: rtl/strip_pkg.sv
// Shared widths, state encodings and default timing constants for the strip frame controller.
package strip_pkg;

  localparam int NUM_LEDS = 5;
  localparam int GRB_W    = NUM_LEDS * 24;

  localparam logic [19:0] FRAME_TICKS_DEF = 20'd833333;
  localparam logic [15:0] GAP_TICKS_DEF   = 16'd15000;
  localparam logic [4:0]  START_TMO_DEF   = 5'd16;

  typedef logic [GRB_W-1:0] grb_t;
  typedef logic [2:0]       state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_LAUNCH     = 3'd1;
  localparam state_t ST_WAIT_START = 3'd2;
  localparam state_t ST_WAIT_DONE  = 3'd3;
  localparam state_t ST_GAP        = 3'd4;

endpackage

// File: rtl/strip_frame_arbiter_rr.sv
// Two-way round-robin arbiter; owns the last-grant history.
// Latency: combinational grant, history updated on the granting edge.
// Backpressure: grants only while en is high; requesters hold their level until granted.
module rr_arbiter2
  import strip_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      // On a tie the requester that did not win last time goes first.
      if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              last_grant <= 1'b1;
    else if (gnt != 2'b00)  last_grant <= gnt[1];
  end

endmodule

// File: rtl/strip_frame_arbiter.sv
// Frame controller sharing one WS2812B sender between two requesters (FRAME_PACE_EN adds fixed-rate pacing).
// Latency: grant one cycle after request in IDLE, Go earliest the cycle after grant.
// Backpressure: waits on sendReady (and the pacing tick); requests outside IDLE stay held by the requester.
module strip_frame_arbiter
  import strip_pkg::*;
#(
  parameter logic [19:0] FRAME_TICKS = FRAME_TICKS_DEF,
  parameter logic [15:0] GAP_TICKS   = GAP_TICKS_DEF,
  parameter logic [4:0]  START_TMO   = START_TMO_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [GRB_W-1:0] seq0,
  input  logic [GRB_W-1:0] seq1,
  output logic             grant0,
  output logic             grant1,
  output logic [GRB_W-1:0] sendGRB,
  output logic             sendGo,
  input  logic             sendReady,
  output logic             busy,
  output logic             frameTick,
  output logic             errStart
);

  state_t      state;
  logic [15:0] gap_cnt;
  logic [4:0]  tmo_cnt;
  logic [1:0]  gnt;
  logic        arb_en;
  logic        launch_ok;
  logic        go_now;

  assign arb_en = (state == ST_IDLE);
  assign go_now = (state == ST_LAUNCH) && launch_ok;
  assign busy   = (state != ST_IDLE);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );

`ifdef FRAME_PACE_EN
  logic [19:0] pace_cnt;
  logic        tick_pending;
  logic        pace_wrap;

  assign pace_wrap = (pace_cnt == FRAME_TICKS - 20'd1);
  assign launch_ok = sendReady && tick_pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pace_cnt     <= 20'd0;
      frameTick    <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      frameTick <= pace_wrap;
      pace_cnt  <= pace_wrap ? 20'd0 : pace_cnt + 20'd1;
      // A wrap coinciding with Go wins, so no period is ever skipped.
      if (pace_wrap)   tick_pending <= 1'b1;
      else if (go_now) tick_pending <= 1'b0;
    end
  end
`else
  logic unused_frame_ticks;
  assign unused_frame_ticks = ^FRAME_TICKS;
  assign launch_ok          = sendReady;
  assign frameTick          = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      gap_cnt  <= 16'd0;
      tmo_cnt  <= 5'd0;
      grant0   <= 1'b0;
      grant1   <= 1'b0;
      sendGRB  <= '0;
      sendGo   <= 1'b0;
      errStart <= 1'b0;
    end else begin
      grant0   <= gnt[0];
      grant1   <= gnt[1];
      sendGo   <= go_now;
      errStart <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            sendGRB <= gnt[1] ? seq1 : seq0;
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (go_now) begin
            tmo_cnt <= 5'd0;
            state   <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (!sendReady) begin
            state <= ST_WAIT_DONE;
          end else if (tmo_cnt == START_TMO - 5'd1) begin
            errStart <= 1'b1;
            gap_cnt  <= 16'd0;
            state    <= ST_GAP;
          end else begin
            tmo_cnt <= tmo_cnt + 5'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (sendReady) begin
            gap_cnt <= 16'd0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // The gap must be an unbroken run of idle-sender cycles.
          if (!sendReady)                         gap_cnt <= 16'd0;
          else if (gap_cnt == GAP_TICKS - 16'd1)  state   <= ST_IDLE;
          else                                    gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strip_frame_arbiter.sv
// Directed bench for strip_frame_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_strip_frame_arbiter;
  import strip_pkg::*;

  localparam logic [19:0] FRAME_T = 20'd200;
  localparam logic [15:0] GAP_T   = 16'd20;
  localparam logic [4:0]  TMO_T   = 5'd16;

  logic clk = 1'b0;
  logic reset;
  logic req0, req1;
  grb_t seq0, seq1;
  logic grant0, grant1, sendGo, sendReady, busy, frameTick, errStart;
  grb_t sendGRB;

  logic       auto_snd;
  logic       man_rdy;
  logic [3:0] snd_cnt;
  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         tick_pulses = 0;
  int         cyc = 0;

  strip_frame_arbiter #(
    .FRAME_TICKS (FRAME_T),
    .GAP_TICKS   (GAP_T),
    .START_TMO   (TMO_T)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .seq0      (seq0),
    .seq1      (seq1),
    .grant0    (grant0),
    .grant1    (grant1),
    .sendGRB   (sendGRB),
    .sendGo    (sendGo),
    .sendReady (sendReady),
    .busy      (busy),
    .frameTick (frameTick),
    .errStart  (errStart)
  );

  always #5 clk = ~clk;

  // Simple sender: drops ready for 8 cycles after seeing Go.
  always @(posedge clk or posedge reset) begin
    if (reset)              snd_cnt <= 4'd0;
    else if (sendGo)        snd_cnt <= 4'd8;
    else if (snd_cnt != 0)  snd_cnt <= snd_cnt - 4'd1;
  end
  assign sendReady = auto_snd ? (snd_cnt == 4'd0) : man_rdy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (errStart)  err_pulses  <= err_pulses + 1;
    if (frameTick) tick_pulses <= tick_pulses + 1;
  end

  typedef struct {
    logic       r0, r1, rdy;
    logic       g0, g1, go, bsy;
    logic [1:0] grb;
  } vec_t;
  vec_t tv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chkg(input string name, input grb_t act, input grb_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic grb_t sel_grb(input logic [1:0] s);
    return (s == 2'd1) ? seq0 : (s == 2'd2) ? seq1 : '0;
  endfunction

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk1({tag, "_grant0"}, grant0, 1'b0);
    chk1({tag, "_grant1"}, grant1, 1'b0);
    chk1({tag, "_sendGo"}, sendGo, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_errStart"}, errStart, 1'b0);
    chk1({tag, "_frameTick"}, frameTick, 1'b0);
    chkg({tag, "_sendGRB"}, sendGRB, '0);
  endtask

  initial begin
    int n, ng, e0, gos;
    int order[3];
    int go_cyc[3];

    seq0     = {15{8'hA5}};
    seq1     = {15{8'h3C}};
    reset    = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    man_rdy  = 1'b1;
    auto_snd = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

`ifdef FRAME_PACE_EN
    // Pacing: Go issues land exactly one frame period apart.
    auto_snd = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    gos  = 0;
    for (int c = 0; c < 3000 && gos < 3; c++) begin
      tick();
      if (sendGo) begin
        go_cyc[gos] = cyc;
        gos++;
      end
    end
    chkn("pace_go_count", gos, 3);
    chkn("pace_spacing1", go_cyc[1] - go_cyc[0], int'(FRAME_T));
    chkn("pace_spacing2", go_cyc[2] - go_cyc[1], int'(FRAME_T));
    chk1("pace_ticks_seen", tick_pulses >= 3, 1'b1);
`else
    tv[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    tv[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    tv[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};

    // Single requester, one full frame through to GAP.
    for (int i = 0; i < 6; i++) begin
      req0    = tv[i].r0;
      req1    = tv[i].r1;
      man_rdy = tv[i].rdy;
      tick();
      chk1($sformatf("v%0d_grant0", i), grant0, tv[i].g0);
      chk1($sformatf("v%0d_grant1", i), grant1, tv[i].g1);
      chk1($sformatf("v%0d_sendGo", i), sendGo, tv[i].go);
      chk1($sformatf("v%0d_busy", i), busy, tv[i].bsy);
      chkg($sformatf("v%0d_sendGRB", i), sendGRB, sel_grb(tv[i].grb));
    end

    // A ready drop inside GAP restarts the count.
    repeat (10) tick();
    man_rdy = 1'b0;
    tick();
    man_rdy = 1'b1;
    wait_idle(n);
    chkn("gap_restart_len", n, int'(GAP_T));

    // Busy falls GAP_TICKS+1 cycles after the sender finishes.
    e0   = err_pulses;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    chk1("gap_go", sendGo, 1'b1);
    repeat (5) tick();
    man_rdy = 1'b0;
    repeat (100) tick();
    chk1("gap_busy_before", busy, 1'b1);
    man_rdy = 1'b1;
    wait_idle(n);
    chkn("gap_busy_fall", n, int'(GAP_T) + 1);
    chkn("gap_no_err", err_pulses - e0, 0);

    // Start timeout: sender never drops ready.
    req1 = 1'b1;
    tick();
    chk1("tmo_grant1", grant1, 1'b1);
    chkg("tmo_sendGRB", sendGRB, seq1);
    req1 = 1'b0;
    tick();
    chk1("tmo_go", sendGo, 1'b1);
    n = 0;
    while (!errStart && n < 100) begin
      tick();
      n++;
    end
    chkn("tmo_len", n, int'(TMO_T));
    tick();
    chk1("tmo_pulse_end", errStart, 1'b0);
    chk1("tmo_busy_gap", busy, 1'b1);
    wait_idle(n);
    chkn("tmo_gap_len", n, int'(GAP_T) - 1);

    // Round robin with both requests held.
    auto_snd = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    ng   = 0;
    for (int c = 0; c < 3000 && ng < 3; c++) begin
      tick();
      if (grant0 || grant1) begin
        order[ng] = grant1 ? 1 : 0;
        chk1($sformatf("rr%0d_onehot", ng), grant0 ^ grant1, 1'b1);
        chkg($sformatf("rr%0d_sendGRB", ng), sendGRB, grant1 ? seq1 : seq0);
        ng++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chkn("rr_count", ng, 3);
    chkn("rr_first", order[0], 0);
    chkn("rr_second", order[1], 1);
    chkn("rr_third", order[2], 0);
    wait_idle(n);
    chk1("rr_idle", n < 2000, 1'b1);

    // Reset in WAIT_DONE, then the next tie must go to req0 again.
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk1("rst_pre_grant1", grant1, 1'b1);
    n = 0;
    while (!sendGo && n < 100) begin
      tick();
      n++;
    end
    chk1("rst_pre_go", sendGo, 1'b1);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();
    chk1("rst_pre_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    tick();
    chk1("postrst_grant0", grant0, 1'b1);
    chk1("postrst_grant1", grant1, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle(n);
    chk1("postrst_idle", n < 2000, 1'b1);
    chkn("no_frame_ticks", tick_pulses, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
